// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared constants and helpers for the button counter blocks
//
// Purpose: default sizes, a one-hot encoder and the counter step rule shared by
//          button_counter and button_counter_arbiter so both update identically.
// Ports:   none (package).
// Config:  BUTTON_ARB_SATURATE_EN selects saturate-at-max instead of wrap-to-zero.
package button_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_NREQ  = 4;

   // Helpers work on the widest supported vectors; callers cast to their size.
   localparam int MAX_W = 32;
   localparam int MAX_N = 8;

   function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
      logic [MAX_N-1:0] r;
      r = '0;
      if (idx >= 0 && idx < n && idx < MAX_N)
         r = MAX_N'(1) << idx;
      return r;
   endfunction

   function automatic logic [MAX_W-1:0] width_max(input int width);
      logic [MAX_W-1:0] m;
      if (width >= MAX_W)
         m = '1;
      else
         m = (MAX_W'(1) << width) - MAX_W'(1);
      return m;
   endfunction

   // True when count + step would exceed the width's all-ones value.
   // Compared against max - step so nothing can overflow (step <= max).
   function automatic logic step_ovf(input logic [MAX_W-1:0] cnt,
                                     input logic [MAX_W-1:0] step,
                                     input int               width);
      return (cnt > (width_max(width) - step));
   endfunction

   function automatic logic [MAX_W-1:0] step_add(input logic [MAX_W-1:0] cnt,
                                                 input logic [MAX_W-1:0] step,
                                                 input int               width);
      logic [MAX_W-1:0] r;
      if (step_ovf(cnt, step, width)) begin
`ifdef BUTTON_ARB_SATURATE_EN
         r = width_max(width);
`else
         r = '0;
`endif
      end else begin
         r = cnt + step;
      end
      return r;
   endfunction

endpackage

// File: rtl/button_counter_arbiter_rr.sv
// rtl/button_counter_arbiter_rr.sv - round-robin arbiter with internal pointer
//
// Purpose: picks the first set request at or above the pointer (wrapping) and
//          moves the pointer just past the winner when told to advance.
// Ports:
//    clk        in   clock
//    rst        in   synchronous active-high reset (pointer to 0)
//    i_req      in   NREQ request vector
//    i_advance  in   consume the current winner (pointer moves past it)
//    i_clear    in   synchronous pointer clear
//    o_gnt      out  one-hot winner (all zero when no request)
//    o_idx      out  winner index (valid when o_gnt is non-zero)
module rr_arbiter
   import button_pkg::*;
#(
   parameter int   NREQ = DEF_NREQ,
   localparam int  IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] i_req,
   input  logic            i_advance,
   input  logic            i_clear,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDXW-1:0] o_idx
);

   localparam int SUMW = IDXW + 1;

   logic [IDXW-1:0] r_ptr;
   logic [NREQ-1:0] w_rot;
   logic [IDXW-1:0] w_off;
   logic [SUMW-1:0] w_sum;
   logic            w_found;
   logic [IDXW-1:0] w_idx;

   // Rotate requests so the pointer position lands at bit 0, take the lowest
   // set bit, then add the pointer back modulo NREQ to get the real index.
   always_comb begin
      w_rot   = NREQ'({i_req, i_req} >> r_ptr);
      w_found = 1'b0;
      w_off   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_off   = IDXW'(k);
         end
      end
      w_sum = {1'b0, r_ptr} + {1'b0, w_off};
      if (w_sum >= SUMW'(NREQ))
         w_sum = w_sum - SUMW'(NREQ);
      w_idx = w_sum[IDXW-1:0];
   end

   assign o_idx = w_idx;
   assign o_gnt = w_found ? NREQ'(onehot(int'(w_idx), NREQ)) : '0;

   always_ff @(posedge clk) begin
      if (rst || i_clear)
         r_ptr <= '0;
      else if (i_advance && w_found)
         r_ptr <= (w_idx == IDXW'(NREQ - 1)) ? '0 : w_idx + IDXW'(1);
   end

endmodule

// File: rtl/button_counter_arbiter.sv
// rtl/button_counter_arbiter.sv - shared step counter fed by NREQ button pulses
//
// Purpose: each requester's single-cycle press is held pending until the
//          round-robin arbiter grants it, at which point its step is added to
//          the shared count (wrapping to 0, or saturating when
//          BUTTON_ARB_SATURATE_EN is defined). One grant per cycle.
// Ports:
//    clk        in   clock
//    rst        in   synchronous active-high reset, beats clear and requests
//    req_pulse  in   NREQ debounced press pulses
//    clear      in   synchronous clear of count, pending and pointer
//    count      out  WIDTH shared counter
//    grant      out  NREQ one-hot, step of requester i applied last edge
//    busy       out  any press pending
//    drop       out  NREQ press lost because requester was already pending
//    sat        out  (BUTTON_ARB_SATURATE_EN only) pulses with a saturating grant
module button_counter_arbiter
   import button_pkg::*;
#(
   parameter int                    NREQ  = DEF_NREQ,
   parameter int                    WIDTH = DEF_WIDTH,
   parameter logic [NREQ*WIDTH-1:0] STEPS = {8'd8, 8'd4, 8'd2, 8'd1}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req_pulse,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic [NREQ-1:0]  grant,
   output logic             busy,
   output logic [NREQ-1:0]  drop
`ifdef BUTTON_ARB_SATURATE_EN
  ,output logic             sat
`endif
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]  r_pending;
   logic [WIDTH-1:0] r_count;
   logic [NREQ-1:0]  r_grant;
   logic [NREQ-1:0]  r_drop;

   logic [NREQ-1:0]  w_win;
   logic [IDXW-1:0]  w_idx;
   logic             w_any;
   logic [WIDTH-1:0] w_step;
   logic [NREQ-1:0]  w_pending_nxt;
   logic [NREQ-1:0]  w_drop_nxt;

   assign w_any = |r_pending;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr (
      .clk       (clk),
      .rst       (rst),
      .i_req     (r_pending),
      .i_advance (w_any),
      .i_clear   (clear),
      .o_gnt     (w_win),
      .o_idx     (w_idx)
   );

   assign w_step = WIDTH'(STEPS >> (int'(w_idx) * WIDTH));

   // A press on the winner re-arms it; a press on any other already-pending
   // requester has nowhere to go and is reported as a drop.
   assign w_pending_nxt = (r_pending & ~w_win) | req_pulse;
   assign w_drop_nxt    = req_pulse & r_pending & ~w_win;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_pending <= '0;
         r_count   <= '0;
         r_grant   <= '0;
         r_drop    <= '0;
      end else begin
         r_pending <= w_pending_nxt;
         r_grant   <= w_win;
         r_drop    <= w_drop_nxt;
         if (w_any)
            r_count <= WIDTH'(step_add(MAX_W'(r_count), MAX_W'(w_step), WIDTH));
      end
   end

`ifdef BUTTON_ARB_SATURATE_EN
   logic r_sat;

   always_ff @(posedge clk) begin
      if (rst || clear)
         r_sat <= 1'b0;
      else
         r_sat <= w_any && step_ovf(MAX_W'(r_count), MAX_W'(w_step), WIDTH);
   end

   assign sat = r_sat;
`endif

   assign count = r_count;
   assign grant = r_grant;
   assign drop  = r_drop;
   assign busy  = w_any;

endmodule

// File: tb/tb_button_counter_arbiter.sv
// tb/tb_button_counter_arbiter.sv - directed vector bench for button_counter_arbiter
module tb_button_counter_arbiter;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       clear;
   logic [3:0] req_pulse;
   logic [7:0] count, count0;
   logic [3:0] grant, grant0;
   logic [3:0] drop, drop0;
   logic       busy, busy0;
`ifdef BUTTON_ARB_SATURATE_EN
   logic       sat, sat0;
   localparam logic [7:0] WRAP_V = 8'd255;
`else
   localparam logic [7:0] WRAP_V = 8'd0;
`endif

   button_counter_arbiter u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_pulse (req_pulse),
      .clear     (clear),
      .count     (count),
      .grant     (grant),
      .busy      (busy),
      .drop      (drop)
`ifdef BUTTON_ARB_SATURATE_EN
     ,.sat       (sat)
`endif
   );

   // Second instance with zero steps on requesters 1..3 and step 5 on requester 0.
   button_counter_arbiter #(
      .STEPS ({8'd0, 8'd0, 8'd0, 8'd5})
   ) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .req_pulse (req_pulse),
      .clear     (clear),
      .count     (count0),
      .grant     (grant0),
      .busy      (busy0),
      .drop      (drop0)
`ifdef BUTTON_ARB_SATURATE_EN
     ,.sat       (sat0)
`endif
   );

   typedef struct {
      logic       rst;
      logic       clr;
      logic [3:0] req;
      logic [7:0] e_count;
      logic [3:0] e_grant;
      logic       e_busy;
      logic [3:0] e_drop;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic add(input logic r, input logic c, input logic [3:0] q,
                      input logic [7:0] ec, input logic [3:0] eg,
                      input logic eb, input logic [3:0] ed);
      vec_t v;
      v.rst = r; v.clr = c; v.req = q;
      v.e_count = ec; v.e_grant = eg; v.e_busy = eb; v.e_drop = ed;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] m);
      req_pulse = m;
      tick();
      req_pulse = '0;
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      clear     = 1'b0;
      req_pulse = '0;

      //   rst clr req      count  grant    busy drop   (values after the edge)
      add(1, 0, 4'b0000,  0, 4'b0000, 0, 4'b0000);
      add(0, 0, 4'b0000,  0, 4'b0000, 0, 4'b0000);
      add(0, 0, 4'b0001,  0, 4'b0000, 1, 4'b0000);   // single press req0
      add(0, 0, 4'b0000,  1, 4'b0001, 0, 4'b0000);
      add(0, 0, 4'b0000,  1, 4'b0000, 0, 4'b0000);
      add(0, 1, 4'b0000,  0, 4'b0000, 0, 4'b0000);   // clear: ptr back to 0
      add(0, 0, 4'b1111,  0, 4'b0000, 1, 4'b0000);   // all four at once
      add(0, 0, 4'b0000,  1, 4'b0001, 1, 4'b0000);
      add(0, 0, 4'b0000,  3, 4'b0010, 1, 4'b0000);
      add(0, 0, 4'b0000,  7, 4'b0100, 1, 4'b0000);
      add(0, 0, 4'b0000, 15, 4'b1000, 0, 4'b0000);
      add(0, 0, 4'b0000, 15, 4'b0000, 0, 4'b0000);
      add(0, 0, 4'b1001, 15, 4'b0000, 1, 4'b0000);   // ptr==0 -> req0 before req3
      add(0, 0, 4'b0000, 16, 4'b0001, 1, 4'b0000);
      add(0, 0, 4'b0000, 24, 4'b1000, 0, 4'b0000);
      add(0, 0, 4'b0111, 24, 4'b0000, 1, 4'b0000);   // req2 behind req0/req1
      add(0, 0, 4'b0100, 25, 4'b0001, 1, 4'b0100);   // second req2 press dropped
      add(0, 0, 4'b0000, 27, 4'b0010, 1, 4'b0000);
      add(0, 0, 4'b0000, 31, 4'b0100, 0, 4'b0000);
      add(0, 0, 4'b0000, 31, 4'b0000, 0, 4'b0000);
      add(0, 0, 4'b0100, 31, 4'b0000, 1, 4'b0000);
      add(0, 0, 4'b0100, 35, 4'b0100, 1, 4'b0000);   // press in own grant cycle
      add(0, 0, 4'b0000, 39, 4'b0100, 0, 4'b0000);
      add(0, 0, 4'b0000, 39, 4'b0000, 0, 4'b0000);
      add(0, 0, 4'b1011, 39, 4'b0000, 1, 4'b0000);
      add(0, 1, 4'b0100,  0, 4'b0000, 0, 4'b0000);   // clear discards all
      add(0, 0, 4'b0000,  0, 4'b0000, 0, 4'b0000);
      add(0, 0, 4'b0010,  0, 4'b0000, 1, 4'b0000);
      add(0, 0, 4'b0000,  2, 4'b0010, 0, 4'b0000);
      add(0, 0, 4'b1101,  2, 4'b0000, 1, 4'b0000);
      add(1, 1, 4'b1111,  0, 4'b0000, 0, 4'b0000);   // rst beats clear
      add(0, 0, 4'b0000,  0, 4'b0000, 0, 4'b0000);

      foreach (vecs[i]) begin
         rst       = vecs[i].rst;
         clear     = vecs[i].clr;
         req_pulse = vecs[i].req;
         tick();
         chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
         chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
         chk($sformatf("v%0d_busy",  i), 32'(busy),  32'(vecs[i].e_busy));
         chk($sformatf("v%0d_drop",  i), 32'(drop),  32'(vecs[i].e_drop));
      end
      rst       = 1'b0;
      clear     = 1'b0;
      req_pulse = '0;

      // Build count 250 then add step 8: 250 > 247 -> wrap (or saturate).
      for (int n = 0; n < 31; n++) press(4'b1000);
      press(4'b0010);
      chk("build_250", 32'(count), 32'd250);
      press(4'b1000);
      chk("wrap_count", 32'(count), 32'(WRAP_V));
      chk("wrap_grant", 32'(grant), 32'b1000);
`ifdef BUTTON_ARB_SATURATE_EN
      chk("wrap_sat", 32'(sat), 32'd1);
`endif
      tick();
      chk("wrap_grant_off", 32'(grant), 32'd0);
`ifdef BUTTON_ARB_SATURATE_EN
      chk("wrap_sat_off", 32'(sat), 32'd0);
`endif

      // Boundary: 247 + 8 lands exactly on 255 without wrapping.
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clear_count", 32'(count), 32'd0);
      for (int n = 0; n < 30; n++) press(4'b1000);
      req_pulse = 4'b0111;
      tick();
      req_pulse = '0;
      tick(); tick(); tick();
      chk("build_247", 32'(count), 32'd247);
      press(4'b1000);
      chk("edge_255", 32'(count), 32'd255);
`ifdef BUTTON_ARB_SATURATE_EN
      chk("edge_sat", 32'(sat), 32'd0);
`endif
      press(4'b0001);
      chk("max_plus1", 32'(count), 32'(WRAP_V));
`ifdef BUTTON_ARB_SATURATE_EN
      chk("max_plus1_sat", 32'(sat), 32'd1);
`endif

      // Zero-step requester still gets a grant but leaves the count alone.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      press(4'b1000);
      chk("main_step8_count", 32'(count), 32'd8);
      chk("zero_step_grant", 32'(grant0), 32'b1000);
      chk("zero_step_count", 32'(count0), 32'd0);
      press(4'b0001);
      chk("step5_count", 32'(count0), 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
